_serial_tx_en: RTL and testbench

Parallel-in, serial-out transmitter that produces the (enable, data) bit stream consumed by the enabled D flip-flop and shift-register receivers in the flip-flop library. A parallel word is loaded on a one-cycle strobe, then driven out one bit per clock on `d_out` while `en_out` is high, MSB first by default. A `done` pulse follows the last bit. The block sits upstream of `_dff_en`-style capture logic and replaces hand-written stimulus sequences in benches and demo top levels.

---
 rtl/_serial_tx_en.sv | 138 +++++++++++++
 tb/tb__serial_tx_en.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/_serial_tx_en.sv
// Parallel-in, serial-out transmitter producing an (en_out, d_out) bit stream
// for enabled-flop capture logic. A word is loaded on a one-cycle strobe. It is
// then shifted out one bit per clock, MSB first by default, and a one-cycle
// done pulse follows the last bit.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   load     start strobe; accepted in IDLE or DONE, ignored while shifting
//   din      parallel word, sampled only on the accepting edge
//   en_out   high exactly while a valid bit is on d_out
//   d_out    serial data bit, forced low whenever en_out is low
//   busy     high while shifting
//   done     one-cycle pulse in the slot after the final bit
module _serial_tx_en #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             en_out,
  output logic             d_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             dat_q, dat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // The bit on d_out lives in dat_q. The shift register holds only the bits
  // still to be sent, aligned so the next one is always at the send end.
  logic             load_first_c;
  logic [WIDTH-1:0] load_rest_c;
  logic             next_bit_c;
  logic [WIDTH-1:0] sh_adv_c;

  // Word alignment for the configured bit order.
  always_comb begin
    if (MSB_FIRST) begin
      load_first_c = din[WIDTH-1];
      load_rest_c  = {din[WIDTH-2:0], 1'b0};
      next_bit_c   = sh_q[WIDTH-1];
      sh_adv_c     = {sh_q[WIDTH-2:0], 1'b0};
    end else begin
      load_first_c = din[0];
      load_rest_c  = {1'b0, din[WIDTH-1:1]};
      next_bit_c   = sh_q[0];
      sh_adv_c     = {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      dat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    dat_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          state_d = ST_SHIFT;
          sh_d    = load_rest_c;
          cnt_d   = '0;
          en_d    = 1'b1;
          dat_d   = load_first_c;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        // cnt_q is the index of the bit currently on d_out.
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          sh_d   = sh_adv_c;
          cnt_d  = cnt_q + CNT_W'(1);
          en_d   = 1'b1;
          dat_d  = next_bit_c;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign en_out = en_q;
  assign d_out  = dat_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb__serial_tx_en.sv
module tb__serial_tx_en;

  logic       clk;
  logic       reset_n;
  logic       load0, load1;
  logic [7:0] din0, din1;
  logic       en0, d0, busy0, done0;
  logic       en1, d1, busy1, done1;
  logic       rx_q;

  int errors;
  int checks;

  _serial_tx_en #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .load(load0), .din(din0),
    .en_out(en0), .d_out(d0), .busy(busy0), .done(done0)
  );

  _serial_tx_en #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .load(load1), .din(din1),
    .en_out(en1), .d_out(d1), .busy(busy1), .done(done1)
  );

  // Enabled D flip-flop receiver attached to the MSB-first transmitter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rx_q <= 1'b0;
    else if (en0)  rx_q <= d0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load0 = 1'b0; load1 = 1'b0;
    din0 = 8'h00; din1 = 8'h00;
    #2;
    checks++;
    if ({en0, d0, busy0, done0} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {en0, d0, busy0, done0});
    end
    tick(); tick();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({en0, d0, busy0, done0, en1, done1} !== 6'b0) begin
        errors++;
        $display("FAIL reset_release_idle[%0d]: got %b expected 000000", i,
                 {en0, d0, busy0, done0, en1, done1});
      end
    end
  endtask

  task automatic test_basic_msb();
    logic [7:0] seq;
    seq = 8'hA5;  // bits in send order: 1,0,1,0,0,1,0,1
    load0 = 1'b1; din0 = 8'hA5;
    tick();
    load0 = 1'b0; din0 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({en0, d0, busy0, done0} !== {1'b1, seq[7-i], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL basic_bit[%0d]: got en/d/busy/done=%b expected %b", i,
                 {en0, d0, busy0, done0}, {1'b1, seq[7-i], 1'b1, 1'b0});
      end
      if (i > 0) begin
        checks++;
        if (rx_q !== seq[8-i]) begin
          errors++;
          $display("FAIL basic_rx[%0d]: got %b expected %b", i-1, rx_q, seq[8-i]);
        end
      end
      tick();
    end
    checks++;
    if ({en0, d0, busy0, done0, rx_q} !== 5'b00011) begin
      errors++;
      $display("FAIL basic_done: got en/d/busy/done/rx=%b expected 00011", {en0, d0, busy0, done0, rx_q});
    end
    tick();
    checks++;
    if ({en0, d0, busy0, done0} !== 4'b0000) begin
      errors++;
      $display("FAIL basic_idle: got %b expected 0000", {en0, d0, busy0, done0});
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] seq;
    seq = 8'h80;  // din=8'h01 LSB first: 1,0,0,0,0,0,0,0
    load1 = 1'b1; din1 = 8'h01;
    tick();
    load1 = 1'b0; din1 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({en1, d1, busy1, done1} !== {1'b1, seq[7-i], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL lsb_bit[%0d]: got %b expected %b", i,
                 {en1, d1, busy1, done1}, {1'b1, seq[7-i], 1'b1, 1'b0});
      end
      tick();
    end
    checks++;
    if ({en1, d1, busy1, done1} !== 4'b0001) begin
      errors++;
      $display("FAIL lsb_done: got %b expected 0001", {en1, d1, busy1, done1});
    end
    din1 = 8'h00;
    tick();
  endtask

  task automatic test_load_while_busy();
    load0 = 1'b1; din0 = 8'h00;
    tick();
    load0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        load0 = 1'b1; din0 = 8'hFF;
      end else begin
        load0 = 1'b0; din0 = 8'h00;
      end
      checks++;
      if ({en0, d0, done0} !== 3'b100) begin
        errors++;
        $display("FAIL busy_bit[%0d]: got en/d/done=%b expected 100", i, {en0, d0, done0});
      end
      tick();
    end
    load0 = 1'b0;
    checks++;
    if ({en0, d0, done0} !== 3'b001) begin
      errors++;
      $display("FAIL busy_done: got %b expected 001", {en0, d0, done0});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({en0, busy0, done0} !== 3'b000) begin
        errors++;
        $display("FAIL busy_no_second[%0d]: got %b expected 000", i, {en0, busy0, done0});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    seq = 16'hF00F;  // first word 1111_0000, second word 0000_1111
    load0 = 1'b1; din0 = 8'hF0;
    tick();
    din0 = 8'h0F;
    for (int i = 0; i < 17; i++) begin
      if (i == 8) begin
        checks++;
        if ({en0, d0, busy0, done0} !== 4'b0001) begin
          errors++;
          $display("FAIL b2b_gap: got %b expected 0001", {en0, d0, busy0, done0});
        end
      end else begin
        checks++;
        if ({en0, d0, done0} !== {1'b1, seq[15 - (i > 8 ? i-1 : i)], 1'b0}) begin
          errors++;
          $display("FAIL b2b_bit[%0d]: got %b expected %b", i, {en0, d0, done0},
                   {1'b1, seq[15 - (i > 8 ? i-1 : i)], 1'b0});
        end
      end
      if (i == 9) load0 = 1'b0;
      tick();
    end
    checks++;
    if ({en0, d0, done0} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_done2: got %b expected 001", {en0, d0, done0});
    end
    tick();
    checks++;
    if ({en0, busy0, done0} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_idle: got %b expected 000", {en0, busy0, done0});
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] seq;
    load0 = 1'b1; din0 = 8'hC3;
    tick();
    load0 = 1'b0;
    tick(); tick(); tick(); tick();  // bit 4 on the line
    checks++;
    if ({en0, d0} !== 2'b10) begin
      errors++;
      $display("FAIL rmid_bit4: got %b expected 10", {en0, d0});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({en0, d0, busy0, done0} !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_async: got %b expected 0000", {en0, d0, busy0, done0});
    end
    tick();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({en0, busy0, done0} !== 3'b000) begin
        errors++;
        $display("FAIL rmid_no_done[%0d]: got %b expected 000", i, {en0, busy0, done0});
      end
    end
    seq = 8'h3C;
    load0 = 1'b1; din0 = 8'h3C;
    tick();
    load0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({en0, d0, done0} !== {1'b1, seq[7-i], 1'b0}) begin
        errors++;
        $display("FAIL rmid_reload[%0d]: got %b expected %b", i, {en0, d0, done0},
                 {1'b1, seq[7-i], 1'b0});
      end
      tick();
    end
    checks++;
    if ({en0, d0, done0} !== 3'b001) begin
      errors++;
      $display("FAIL rmid_reload_done: got %b expected 001", {en0, d0, done0});
    end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_msb();
    test_lsb_first();
    test_load_while_busy();
    test_back_to_back();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
